// File: rtl/shifter_readout_ctrl_pkg.sv
// Shared definitions for the error-count readout framer.
// Used by the RTL and available to host-side decoders.
package shifter_readout_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SNAP    = 3'd1,
      ST_HDR     = 3'd2,
      ST_PAYLOAD = 3'd3,
      ST_PARITY  = 3'd4,
      ST_GAP     = 3'd5
   } state_e;

   localparam logic [7:0] HDR_DEFAULT = 8'hA5;
   localparam int         HDR_BITS    = 8;

   // SNAP through PARITY inclusive
   function automatic int frame_len(input int num_chains, input int cnt_w);
      return 1 + HDR_BITS + num_chains * cnt_w + 1;
   endfunction

   function automatic int frame_period(input int num_chains, input int cnt_w, input int gap_cycles);
      return frame_len(num_chains, cnt_w) + gap_cycles;
   endfunction

   function automatic logic parity_step(input logic acc, input logic din);
      return acc ^ din;
   endfunction

endpackage

// File: rtl/shifter_readout_serdes.sv
// Snapshot register and payload serialiser: walks chains, LSB first,
// and keeps a running even-parity accumulator over the emitted bits.
module shifter_readout_serdes
   import shifter_readout_ctrl_pkg::*;
#(
   parameter int NUM_CHAINS = 2,
   parameter int CNT_W      = 12
) (
   input  logic                        DATA_CLK,
   input  logic                        RST,
   input  logic                        snap_en_s,
   input  logic                        shift_en_s,
   input  logic [NUM_CHAINS*CNT_W-1:0] err_cnt_s,
   output logic                        ser_bit_s,
   output logic                        parity_s,
   output logic                        last_s
);

   localparam int TOTAL_W = NUM_CHAINS * CNT_W;
   localparam int BIT_W   = (CNT_W > 1) ? $clog2(CNT_W) : 1;
   localparam int CHAIN_W = $clog2(NUM_CHAINS + 1);
   localparam int IDX_W   = (TOTAL_W > 1) ? $clog2(TOTAL_W) : 1;

   localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(CNT_W - 1);
   localparam logic [CHAIN_W-1:0] CHAIN_END = CHAIN_W'(NUM_CHAINS);

   logic [TOTAL_W-1:0] snap_r;
   logic [BIT_W-1:0]   bit_cnt_r;
   logic [CHAIN_W-1:0] chain_cnt_r;
   logic               parity_r;
   logic [IDX_W-1:0]   idx_s;

   assign parity_s = parity_r;
   assign last_s   = (chain_cnt_r == CHAIN_END);

   // bit mux: counters always point at the next payload bit to emit
   always_comb begin
      idx_s     = IDX_W'(chain_cnt_r) * IDX_W'(CNT_W) + IDX_W'(bit_cnt_r);
      ser_bit_s = 1'b0;
      if (last_s) begin
         ser_bit_s = 1'b0;
      end else begin
         ser_bit_s = snap_r[idx_s];
      end
   end

   // snapshot capture, bit/chain counters and parity accumulation
   always_ff @(posedge DATA_CLK or negedge RST) begin
      if (!RST) begin
         snap_r      <= {TOTAL_W{1'b0}};
         bit_cnt_r   <= {BIT_W{1'b0}};
         chain_cnt_r <= {CHAIN_W{1'b0}};
         parity_r    <= 1'b0;
      end else if (snap_en_s) begin
         snap_r      <= err_cnt_s;
         bit_cnt_r   <= {BIT_W{1'b0}};
         chain_cnt_r <= {CHAIN_W{1'b0}};
         parity_r    <= 1'b0;
      end else if (shift_en_s && !last_s) begin
         parity_r <= parity_step(parity_r, ser_bit_s);
         if (bit_cnt_r == BIT_LAST) begin
            bit_cnt_r   <= {BIT_W{1'b0}};
            chain_cnt_r <= chain_cnt_r + CHAIN_W'(1);
         end else begin
            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
         end
      end
   end

endmodule

// File: rtl/shifter_readout_ctrl.sv
// Frame controller: snapshot strobe, header, serial payload, parity, gap.
// Outputs are registered from the next state so they line up with it.
module shifter_readout_ctrl
   import shifter_readout_ctrl_pkg::*;
#(
   parameter int         NUM_CHAINS = 2,
   parameter int         CNT_W      = 12,
   parameter logic [7:0] HDR        = HDR_DEFAULT,
   parameter int         GAP_CYCLES = 4
) (
   input  logic                        DATA_CLK,
   input  logic                        RST,
   input  logic                        ENABLE,
   input  logic                        TRIGGER,
   input  logic [NUM_CHAINS*CNT_W-1:0] ERR_CNT,
   output logic                        SAVE_DATA,
   output logic                        DATA_OUT,
   output logic                        FRAME_SYNC,
   output logic                        BUSY,
   output logic [7:0]                  FRAME_CNT
);

   localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   state_e           state_r;
   state_e           state_s;
   logic [2:0]       hdr_cnt_r;
   logic [2:0]       hdr_cnt_s;
   logic [GAP_W-1:0] gap_cnt_r;
   logic [GAP_W-1:0] gap_cnt_s;
   logic             data_out_s;
   logic             save_data_r;
   logic             data_out_r;
   logic             frame_sync_r;
   logic             busy_r;
   logic [7:0]       frame_cnt_r;
   logic             snap_en_s;
   logic             shift_en_s;
   logic             ser_bit_s;
   logic             parity_s;
   logic             last_s;

   assign SAVE_DATA  = save_data_r;
   assign DATA_OUT   = data_out_r;
   assign FRAME_SYNC = frame_sync_r;
   assign BUSY       = busy_r;
   assign FRAME_CNT  = frame_cnt_r;

   assign snap_en_s  = (state_r == ST_SNAP);
   assign shift_en_s = (state_s == ST_PAYLOAD);

   shifter_readout_serdes #(
      .NUM_CHAINS (NUM_CHAINS),
      .CNT_W      (CNT_W)
   ) u_serdes (
      .DATA_CLK   (DATA_CLK),
      .RST        (RST),
      .snap_en_s  (snap_en_s),
      .shift_en_s (shift_en_s),
      .err_cnt_s  (ERR_CNT),
      .ser_bit_s  (ser_bit_s),
      .parity_s   (parity_s),
      .last_s     (last_s)
   );

   // next-state decode; TRIGGER is only looked at in IDLE
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (TRIGGER || ENABLE) begin
               state_s = ST_SNAP;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SNAP:    state_s = ST_HDR;
         ST_HDR: begin
            if (hdr_cnt_r == 3'd7) begin
               state_s = ST_PAYLOAD;
            end else begin
               state_s = ST_HDR;
            end
         end
         ST_PAYLOAD: begin
            if (last_s) begin
               state_s = ST_PARITY;
            end else begin
               state_s = ST_PAYLOAD;
            end
         end
         ST_PARITY:  state_s = ST_GAP;
         ST_GAP: begin
            if (gap_cnt_r != GAP_LAST) begin
               state_s = ST_GAP;
            end else if (ENABLE) begin
               state_s = ST_SNAP;
            end else begin
               state_s = ST_IDLE;
            end
         end
         default:    state_s = ST_IDLE;
      endcase
   end

   // output bit and position counters for the cycle being entered
   always_comb begin
      hdr_cnt_s  = 3'd0;
      gap_cnt_s  = {GAP_W{1'b0}};
      data_out_s = 1'b0;
      case (state_s)
         ST_HDR: begin
            if (state_r == ST_HDR) begin
               hdr_cnt_s = hdr_cnt_r + 3'd1;
            end else begin
               hdr_cnt_s = 3'd0;
            end
            data_out_s = HDR[3'd7 - hdr_cnt_s];
         end
         ST_PAYLOAD: data_out_s = ser_bit_s;
         ST_PARITY:  data_out_s = parity_s;
         ST_GAP: begin
            if (state_r == ST_GAP) begin
               gap_cnt_s = gap_cnt_r + GAP_W'(1);
            end else begin
               gap_cnt_s = {GAP_W{1'b0}};
            end
         end
         default:    data_out_s = 1'b0;
      endcase
   end

   // state, counters and registered outputs
   always_ff @(posedge DATA_CLK or negedge RST) begin
      if (!RST) begin
         state_r      <= ST_IDLE;
         hdr_cnt_r    <= 3'd0;
         gap_cnt_r    <= {GAP_W{1'b0}};
         save_data_r  <= 1'b0;
         data_out_r   <= 1'b0;
         frame_sync_r <= 1'b0;
         busy_r       <= 1'b0;
         frame_cnt_r  <= 8'd0;
      end else begin
         state_r      <= state_s;
         hdr_cnt_r    <= hdr_cnt_s;
         gap_cnt_r    <= gap_cnt_s;
         save_data_r  <= (state_s == ST_SNAP);
         data_out_r   <= data_out_s;
         frame_sync_r <= (state_s == ST_HDR) && (state_r == ST_SNAP);
         busy_r       <= (state_s != ST_IDLE);
         if (state_s == ST_PARITY) begin
            frame_cnt_r <= frame_cnt_r + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_shifter_readout_ctrl.sv
// Directed self-checking bench for shifter_readout_ctrl at default parameters.
module tb_shifter_readout_ctrl;

   logic        DATA_CLK = 1'b0;
   logic        RST      = 1'b0;
   logic        ENABLE   = 1'b0;
   logic        TRIGGER  = 1'b0;
   logic [23:0] ERR_CNT  = 24'h0;
   logic        SAVE_DATA;
   logic        DATA_OUT;
   logic        FRAME_SYNC;
   logic        BUSY;
   logic [7:0]  FRAME_CNT;

   int total = 0;
   int bad   = 0;
   int cap_n = 0;

   logic data_a [0:255];
   logic busy_a [0:255];
   logic save_a [0:255];
   logic sync_a [0:255];

   // A5, chain0=801 LSB first, chain1=00F LSB first, parity 0
   localparam logic [32:0] EXP_F801 = 33'b1010_0101_1000_0000_0001_1111_0000_0000_0;
   localparam logic [32:0] EXP_0001 = {8'hA5, 1'b1, 23'd0, 1'b1};

   shifter_readout_ctrl #(
      .NUM_CHAINS (2),
      .CNT_W      (12),
      .HDR        (8'hA5),
      .GAP_CYCLES (4)
   ) dut (
      .DATA_CLK   (DATA_CLK),
      .RST        (RST),
      .ENABLE     (ENABLE),
      .TRIGGER    (TRIGGER),
      .ERR_CNT    (ERR_CNT),
      .SAVE_DATA  (SAVE_DATA),
      .DATA_OUT   (DATA_OUT),
      .FRAME_SYNC (FRAME_SYNC),
      .BUSY       (BUSY),
      .FRAME_CNT  (FRAME_CNT)
   );

   always #5 DATA_CLK = ~DATA_CLK;

   // sample outputs on n falling edges, appending at cap_n+1..; optional trigger pulse
   task automatic run_cycles(input int n, input bit pulse);
      if (pulse) TRIGGER = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge DATA_CLK);
         if (pulse && i == 0) TRIGGER = 1'b0;
         cap_n = cap_n + 1;
         data_a[cap_n] = DATA_OUT;
         busy_a[cap_n] = BUSY;
         save_a[cap_n] = SAVE_DATA;
         sync_a[cap_n] = FRAME_SYNC;
      end
   endtask

   function automatic logic [32:0] stream_at(input int t0);
      logic [32:0] s;
      for (int i = 0; i < 33; i++) s[32-i] = data_a[t0+i];
      return s;
   endfunction

   function automatic logic [23:0] payload_at(input int t0);
      logic [23:0] p;
      for (int i = 0; i < 24; i++) p[i] = data_a[t0+i];
      return p;
   endfunction

   task automatic test_reset();
      logic [11:0] obs;
      RST = 1'b0;
      repeat (2) @(negedge DATA_CLK);
      obs = {SAVE_DATA, DATA_OUT, FRAME_SYNC, BUSY, FRAME_CNT};
      total++;
      if (obs !== 12'h000) begin bad++; $display("FAIL reset_held got=%h exp=000", obs); end
      RST = 1'b1;
      repeat (2) @(negedge DATA_CLK);
      obs = {SAVE_DATA, DATA_OUT, FRAME_SYNC, BUSY, FRAME_CNT};
      total++;
      if (obs !== 12'h000) begin bad++; $display("FAIL reset_idle got=%h exp=000", obs); end
   endtask

   task automatic test_single_frame();
      int ns, ny, nb;
      logic [3:0] gap;
      cap_n = 0;
      ERR_CNT = 24'h00F801;
      run_cycles(40, 1'b1);
      ns = 0; ny = 0; nb = 0;
      for (int t = 1; t <= 40; t++) begin
         ns += int'(save_a[t]);
         ny += int'(sync_a[t]);
      end
      for (int t = 1; t <= 38; t++) nb += int'(busy_a[t]);
      total++;
      if (!(save_a[1] === 1'b1 && ns == 1)) begin bad++; $display("FAIL single_save first=%b count=%0d exp=1/1", save_a[1], ns); end
      total++;
      if (!(sync_a[2] === 1'b1 && ny == 1)) begin bad++; $display("FAIL single_sync at2=%b count=%0d exp=1/1", sync_a[2], ny); end
      total++;
      if (stream_at(2) !== EXP_F801) begin bad++; $display("FAIL single_stream got=%b exp=%b", stream_at(2), EXP_F801); end
      gap = {data_a[35], data_a[36], data_a[37], data_a[38]};
      total++;
      if (gap !== 4'b0000) begin bad++; $display("FAIL single_gap got=%b exp=0000", gap); end
      total++;
      if (!(nb == 38 && busy_a[39] === 1'b0)) begin bad++; $display("FAIL single_busy high=%0d at39=%b exp=38/0", nb, busy_a[39]); end
      total++;
      if (FRAME_CNT !== 8'd1) begin bad++; $display("FAIL single_fcnt got=%0d exp=1", FRAME_CNT); end
   endtask

   task automatic test_continuous();
      logic [7:0] f0;
      int ns, ny, nb;
      f0 = FRAME_CNT;
      cap_n = 0;
      ERR_CNT = 24'h000001;
      ENABLE = 1'b1;
      run_cycles(80, 1'b0);
      ENABLE = 1'b0;
      run_cycles(45, 1'b0);
      ns = 0; ny = 0; nb = 0;
      for (int t = 1; t <= 125; t++) begin
         ns += int'(save_a[t]);
         ny += int'(sync_a[t]);
      end
      for (int t = 1; t <= 114; t++) nb += int'(busy_a[t]);
      total++;
      if (!({save_a[1], save_a[39], save_a[77]} === 3'b111 && ns == 3)) begin
         bad++; $display("FAIL cont_save pos=%b%b%b count=%0d exp=111/3", save_a[1], save_a[39], save_a[77], ns);
      end
      total++;
      if (!({sync_a[2], sync_a[40], sync_a[78]} === 3'b111 && ny == 3)) begin
         bad++; $display("FAIL cont_sync pos=%b%b%b count=%0d exp=111/3", sync_a[2], sync_a[40], sync_a[78], ny);
      end
      total++;
      if ({data_a[34], data_a[72], data_a[110]} !== 3'b111) begin
         bad++; $display("FAIL cont_parity got=%b%b%b exp=111", data_a[34], data_a[72], data_a[110]);
      end
      total++;
      if (payload_at(48) !== 24'h000001) begin bad++; $display("FAIL cont_payload2 got=%h exp=000001", payload_at(48)); end
      total++;
      if (stream_at(78) !== EXP_0001) begin bad++; $display("FAIL cont_stream3 got=%b exp=%b", stream_at(78), EXP_0001); end
      total++;
      if (!(nb == 114 && busy_a[115] === 1'b0)) begin bad++; $display("FAIL cont_busy high=%0d at115=%b exp=114/0", nb, busy_a[115]); end
      total++;
      if (FRAME_CNT !== f0 + 8'd3) begin bad++; $display("FAIL cont_fcnt got=%0d exp=%0d", FRAME_CNT, f0 + 8'd3); end
   endtask

   task automatic test_snapshot_hold();
      cap_n = 0;
      ERR_CNT = 24'h5A3C96;
      run_cycles(3, 1'b1);
      ERR_CNT = 24'hFFFFFF;
      run_cycles(37, 1'b0);
      total++;
      if (payload_at(10) !== 24'h5A3C96) begin bad++; $display("FAIL snap_payload got=%h exp=5a3c96", payload_at(10)); end
      total++;
      if (data_a[34] !== 1'b0) begin bad++; $display("FAIL snap_parity got=%b exp=0", data_a[34]); end
      ERR_CNT = 24'h0;
   endtask

   task automatic test_trigger_busy();
      logic [7:0] f0;
      int ns, nb;
      f0 = FRAME_CNT;
      cap_n = 0;
      ERR_CNT = 24'h00F801;
      run_cycles(15, 1'b1);
      TRIGGER = 1'b1;
      run_cycles(1, 1'b0);
      TRIGGER = 1'b0;
      run_cycles(19, 1'b0);
      TRIGGER = 1'b1;
      run_cycles(1, 1'b0);
      TRIGGER = 1'b0;
      run_cycles(14, 1'b0);
      ns = 0; nb = 0;
      for (int t = 1; t <= 50; t++) ns += int'(save_a[t]);
      for (int t = 39; t <= 50; t++) nb += int'(busy_a[t]);
      total++;
      if (ns != 1) begin bad++; $display("FAIL busy_trig_save count=%0d exp=1", ns); end
      total++;
      if (!(busy_a[38] === 1'b1 && nb == 0)) begin bad++; $display("FAIL busy_trig_busy at38=%b later_high=%0d exp=1/0", busy_a[38], nb); end
      total++;
      if (stream_at(2) !== EXP_F801) begin bad++; $display("FAIL busy_trig_stream got=%b exp=%b", stream_at(2), EXP_F801); end
      total++;
      if (FRAME_CNT !== f0 + 8'd1) begin bad++; $display("FAIL busy_trig_fcnt got=%0d exp=%0d", FRAME_CNT, f0 + 8'd1); end
   endtask

   task automatic test_reset_mid_frame();
      int nb;
      RST = 1'b0;
      @(negedge DATA_CLK);
      RST = 1'b1;
      @(negedge DATA_CLK);
      cap_n = 0;
      ERR_CNT = 24'h000020;
      run_cycles(15, 1'b1);
      total++;
      if ({data_a[15], busy_a[15]} !== 2'b11) begin bad++; $display("FAIL rstmid_pre got=%b%b exp=11", data_a[15], busy_a[15]); end
      #2 RST = 1'b0;
      #1;
      total++;
      if ({DATA_OUT, BUSY, FRAME_SYNC, SAVE_DATA, FRAME_CNT} !== 12'h000) begin
         bad++; $display("FAIL rstmid_async got=%b%b%b%b fcnt=%0d exp=0000/0", DATA_OUT, BUSY, FRAME_SYNC, SAVE_DATA, FRAME_CNT);
      end
      @(negedge DATA_CLK);
      @(negedge DATA_CLK);
      RST = 1'b1;
      cap_n = 0;
      run_cycles(3, 1'b0);
      nb = int'(busy_a[1]) + int'(busy_a[2]) + int'(busy_a[3]);
      total++;
      if (nb != 0) begin bad++; $display("FAIL rstmid_norestart busy_cycles=%0d exp=0", nb); end
      cap_n = 0;
      ERR_CNT = 24'h00F801;
      run_cycles(40, 1'b1);
      total++;
      if (stream_at(2) !== EXP_F801) begin bad++; $display("FAIL rstmid_stream got=%b exp=%b", stream_at(2), EXP_F801); end
      total++;
      if (FRAME_CNT !== 8'd1) begin bad++; $display("FAIL rstmid_fcnt got=%0d exp=1", FRAME_CNT); end
   endtask

   task automatic test_wrap();
      int bad_frames, nsave, ny;
      RST = 1'b0;
      @(negedge DATA_CLK);
      RST = 1'b1;
      @(negedge DATA_CLK);
      ERR_CNT = 24'h00F801;
      bad_frames = 0;
      nsave = 0;
      for (int f = 0; f < 256; f++) begin
         cap_n = 0;
         run_cycles(39, 1'b1);
         ny = 0;
         for (int t = 1; t <= 39; t++) begin
            ny += int'(sync_a[t]);
            nsave += int'(save_a[t]);
         end
         if (ny != 1 || sync_a[2] !== 1'b1) bad_frames++;
         if (f == 254) begin
            total++;
            if (FRAME_CNT !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d exp=255", FRAME_CNT); end
         end
      end
      total++;
      if (FRAME_CNT !== 8'd0) begin bad++; $display("FAIL wrap_zero got=%0d exp=0", FRAME_CNT); end
      total++;
      if (bad_frames != 0) begin bad++; $display("FAIL wrap_sync bad_frames=%0d exp=0", bad_frames); end
      total++;
      if (nsave != 256) begin bad++; $display("FAIL wrap_save count=%0d exp=256", nsave); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_continuous();
      test_snapshot_hold();
      test_trigger_busy();
      test_reset_mid_frame();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
